// File: rtl/stream_demux_if.sv
// +--------------------------------------------------------------------+
// | stream_demux_if : input and per-channel output handshake bundle    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT)
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_bcast;
  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic [N_OUT*DATA_W-1:0]   out_data;

  // master: upstream source plus downstream consumers; slave: the demux
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/stream_demux.sv
// +--------------------------------------------------------------------+
// | stream_demux : registered 1-to-N valid/ready demux with broadcast  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_OUT-1:0]              valid_q, valid_d;
  logic [N_OUT-1:0][DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]              drop_cnt_q, drop_cnt_d;

  logic [N_OUT-1:0]              w_can_load;
  logic [N_OUT-1:0]              w_sel_hit;
  logic [N_OUT-1:0]              w_load;
  logic                          w_sel_in_range;
  logic                          w_in_ready;
  logic                          w_accept;

  // An out-of-range select matches no channel, so range is just "any hit".
  always_comb begin
    w_can_load = ~valid_q | bus.out_ready;
    w_sel_hit  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_sel_hit[i] = (bus.in_sel == SEL_W'(i));
    end
    w_sel_in_range = |w_sel_hit;

    if (bus.in_bcast) begin
      w_in_ready = &w_can_load;
    end else if (w_sel_in_range) begin
      w_in_ready = |(w_sel_hit & w_can_load);
    end else begin
      w_in_ready = 1'b1;
    end

    w_accept = bus.in_valid && w_in_ready;
    w_load   = '0;
    if (w_accept) begin
      w_load = bus.in_bcast ? {N_OUT{1'b1}} : w_sel_hit;
    end
  end

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (w_load[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data;
      end else if (bus.out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (w_accept && !bus.in_bcast && !w_sel_in_range && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// +--------------------------------------------------------------------+
// | tb_stream_demux : scoreboard bench for stream_demux (N=8 and N=6)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] drop8;
  logic [7:0] drop6;

  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) bus8 ();
  stream_demux_if #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) bus6 ();

  stream_demux #(.DATA_W(8), .N_OUT(8), .SEL_W(3), .CNT_W(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus8.slave),
    .drop_cnt (drop8)
  );

  stream_demux #(.DATA_W(8), .N_OUT(6), .SEL_W(3), .CNT_W(8)) dut6 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus6.slave),
    .drop_cnt (drop6)
  );

  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model: per-channel queue of words still owed to each consumer
  logic [7:0] exp_q [8][$];
  logic [7:0] m_full = '0;

  logic [7:0] prev_stall = '0;
  logic [7:0] prev_data [8];
  logic [7:0] mon_w;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle on the N=8 instance; called at posedge+1, returns at posedge+1
  task automatic step8(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic b, input logic [7:0] rdy, output logic acc);
    logic [7:0] can;
    logic       exp_rdy;
    bus8.in_valid  = v;
    bus8.in_data   = d;
    bus8.in_sel    = s;
    bus8.in_bcast  = b;
    bus8.out_ready = rdy;
    @(negedge clk);
    can     = ~m_full | rdy;
    exp_rdy = b ? (&can) : can[s];
    check("in_ready", {31'd0, bus8.in_ready}, {31'd0, exp_rdy});
    check("out_valid", {24'd0, bus8.out_valid}, {24'd0, m_full});
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    m_full = m_full & ~rdy;
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        if (b || (s == 3'(i))) begin
          m_full[i] = 1'b1;
          exp_q[i].push_back(d);
        end
      end
    end
  endtask

  // Monitor: pops on every drain and checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mon_w = bus8.out_data[i*8 +: 8];
        if (prev_stall[i]) begin
          check("hold_valid", {31'd0, bus8.out_valid[i]}, 32'd1);
          check("hold_data", {24'd0, mon_w}, {24'd0, prev_data[i]});
        end
        if (bus8.out_valid[i] && bus8.out_ready[i]) begin
          check("drain_expected", {31'd0, exp_q[i].size() != 0}, 32'd1);
          if (exp_q[i].size() != 0) begin
            mon_exp = exp_q[i].pop_front();
            check("drain_data", {24'd0, mon_w}, {24'd0, mon_exp});
          end
        end
        prev_stall[i] = bus8.out_valid[i] && !bus8.out_ready[i];
        prev_data[i]  = mon_w;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic       pv, pb, pacc;
    logic [7:0] pd;
    logic [2:0] ps;

    bus8.in_valid = 0; bus8.in_data = 0; bus8.in_sel = 0; bus8.in_bcast = 0; bus8.out_ready = 0;
    bus6.in_valid = 0; bus6.in_data = 0; bus6.in_sel = 0; bus6.in_bcast = 0; bus6.out_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {24'd0, bus8.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    check("rst_drop6", {24'd0, drop6}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Routing at full rate
    step8(1, 8'hA5, 3, 0, 8'hFF, acc);
    step8(1, 8'h3C, 7, 0, 8'hFF, acc);
    check("route_ch3", {24'd0, bus8.out_data[3*8 +: 8]}, 32'hA5);
    step8(0, 8'h00, 0, 0, 8'hFF, acc);
    check("route_ch7", {24'd0, bus8.out_data[7*8 +: 8]}, 32'h3C);

    // Backpressure on channel 3 only
    step8(1, 8'h11, 3, 0, 8'hF7, acc);
    step8(1, 8'h33, 4, 0, 8'hF7, acc);
    check("bp_other_acc", {31'd0, acc}, 32'd1);
    step8(1, 8'h22, 3, 0, 8'hF7, acc);
    check("bp_blocked", {31'd0, acc}, 32'd0);
    check("bp_hold", {24'd0, bus8.out_data[3*8 +: 8]}, 32'h11);
    step8(1, 8'h22, 3, 0, 8'hFF, acc);
    check("bp_replace", {24'd0, bus8.out_data[3*8 +: 8]}, 32'h22);
    step8(0, 8'h00, 0, 0, 8'hFF, acc);

    // Broadcast blocked by one full channel
    step8(1, 8'h77, 0, 0, 8'hFE, acc);
    step8(1, 8'h5A, 0, 1, 8'hFE, acc);
    check("bc_blocked", {31'd0, acc}, 32'd0);
    step8(1, 8'h5A, 0, 1, 8'hFF, acc);
    check("bc_accept", {31'd0, acc}, 32'd1);
    step8(0, 8'h00, 0, 0, 8'h00, acc);
    for (int i = 0; i < 8; i++) check("bc_data", {24'd0, bus8.out_data[i*8 +: 8]}, 32'h5A);
    step8(0, 8'h00, 0, 0, 8'hFF, acc);

    // Random stress with protocol-correct holding of refused words
    pv = 0; pd = 0; ps = 0; pb = 0; pacc = 1;
    for (int k = 0; k < 10000; k++) begin
      if (!(pv && !pacc)) begin
        pv = ($urandom_range(0, 3) != 0);
        pd = 8'($urandom);
        ps = 3'($urandom);
        pb = ($urandom_range(0, 7) == 0);
      end
      step8(pv, pd, ps, pb, 8'($urandom | $urandom), pacc);
    end
    repeat (3) step8(0, 8'h00, 0, 0, 8'hFF, acc);
    for (int i = 0; i < 8; i++) check("q_empty", exp_q[i].size(), 32'd0);
    check("drop8_zero", {24'd0, drop8}, 32'd0);

    // N_OUT=6: in-range word, then out-of-range drops
    bus6.in_valid = 1; bus6.in_data = 8'hC3; bus6.in_sel = 3'd5; bus6.out_ready = '0;
    @(posedge clk);
    #1;
    bus6.in_valid = 0;
    check("n6_valid", {26'd0, bus6.out_valid}, 32'h20);
    check("n6_data", {24'd0, bus6.out_data[5*8 +: 8]}, 32'hC3);
    bus6.out_ready = '1;
    @(posedge clk);
    #1;
    check("n6_drained", {26'd0, bus6.out_valid}, 32'd0);
    for (int k = 0; k < 300; k++) begin
      bus6.in_valid  = 1;
      bus6.in_sel    = (k % 2 == 1) ? 3'd7 : 3'd6;
      bus6.in_data   = 8'($urandom);
      bus6.out_ready = 6'($urandom);
      @(negedge clk);
      check("drop_in_ready", {31'd0, bus6.in_ready}, 32'd1);
      check("drop_out_valid", {26'd0, bus6.out_valid}, 32'd0);
      if (k == 100) check("drop_cnt_mid", {24'd0, drop6}, 32'd100);
      @(posedge clk);
      #1;
    end
    bus6.in_valid = 0;
    check("drop_cnt_sat", {24'd0, drop6}, 32'd255);

    // Asynchronous reset with channels 2 and 5 holding words
    step8(1, 8'h44, 2, 0, 8'h00, acc);
    step8(1, 8'h99, 5, 0, 8'h00, acc);
    check("pre_rst_valid", {24'd0, bus8.out_valid}, 32'h24);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {24'd0, bus8.out_valid}, 32'd0);
    check("arst_data", bus8.out_data[31:0] | bus8.out_data[63:32], 32'd0);
    check("arst_drop6", {24'd0, drop6}, 32'd0);
    check("arst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    bus8.in_valid = 0;
    m_full = '0;
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step8(1, 8'hE1, 6, 0, 8'h00, acc);
    check("post_rst_acc", {31'd0, acc}, 32'd1);
    step8(0, 8'h00, 0, 0, 8'hFF, acc);
    step8(0, 8'h00, 0, 0, 8'hFF, acc);
    for (int i = 0; i < 8; i++) check("q_empty_end", exp_q[i].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking on the input and on every output channel. Each accepted word is steered by a select field to one output channel, or copied to all channels in broadcast mode, and held in a one-entry per-channel output register until that channel's consumer takes it. It replaces the combinational 1-to-8 demultiplexer wherever the downstream consumers can stall. It also counts words dropped because of an out-of-range select.

## Interface
Parameters:
- DATA_W, 8, width of the data word
- N_OUT, 8, number of output channels (2..256)
- SEL_W, $clog2(N_OUT), width of the select field
- CNT_W, 8, width of the drop counter

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts the word this cycle
- in_data  input  DATA_W  input word
- in_sel  input  SEL_W  target channel index
- in_bcast  input  1  1 = copy the word to all N_OUT channels; in_sel ignored
- out_valid  output  N_OUT  bit i = channel i holds a word
- out_ready  input  N_OUT  bit i = consumer i takes the word this cycle
- out_data  output  N_OUT*DATA_W  channel i word on bits [i*DATA_W +: DATA_W]
- drop_cnt  output  CNT_W  saturating count of words dropped for out-of-range select

## Operation
- Per-channel storage: one register holding out_valid[i] and data[i].
- Load condition: can_load[i] = !out_valid[i] || out_ready[i].
- in_ready is combinational from in_sel, in_bcast, out_valid and out_ready:
  - in_bcast=1: in_ready = AND of can_load over all channels.
  - in_bcast=0, in_sel < N_OUT: in_ready = can_load[in_sel].
  - in_bcast=0, in_sel >= N_OUT: in_ready = 1.
- Accept means in_valid && in_ready at a rising edge.
- Accept with in_bcast=1: every channel loads in_data and sets out_valid.
- Accept with in_bcast=0 and a valid select: only channel in_sel loads. Other channels are unaffected.
- Accept with in_sel >= N_OUT: the word is discarded and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1 and never wraps. Out-of-range selects are only possible when N_OUT is not a power of 2.
- Drain: out_valid[i] && out_ready[i] with no load to channel i in the same cycle clears out_valid[i].
- Simultaneous drain and load on channel i: the new word replaces the old one and out_valid[i] stays 1, giving full throughput.
- Channels drain independently; a stalled channel blocks only words addressed to it, plus broadcasts.
- out_data[i] holds its value while out_valid[i]=1 and out_ready[i]=0, and stays at the last value after a drain.
- Upstream protocol: in_data, in_sel and in_bcast are held stable while in_valid=1 && in_ready=0. The block does not require in_valid to stay high.

## Timing
- Latency: a word accepted at edge k appears on out_valid/out_data immediately after edge k.
- Throughput: one word per cycle, provided the target channel's consumer keeps out_ready high.
- There is a combinational path from out_ready and in_sel/in_bcast to in_ready. Integrators must not close a combinational loop through the upstream source.
- Reset (rst_n=0, asynchronous assert, synchronous deassert by the integrator):
  - out_valid = 0 on all channels.
  - out_data = 0 on all channels.
  - drop_cnt = 0.
  - in_ready follows the equations above; with all channels empty it reads 1.
- Reset mid-operation discards every buffered word; no output is produced from pre-reset data.
- The first accept can occur on the first rising edge after rst_n deasserts.

## Test plan
- Reset: DATA_W=8, N_OUT=8. Assert rst_n=0 while channels 2 and 5 hold words -> out_valid=8'h00, out_data=0 and drop_cnt=0 immediately, with no clock edge needed.
- Routing: out_ready=8'hFF, send data=8'hA5 to sel=3 and then 8'h3C to sel=7 on consecutive cycles -> out_valid=8'h08 with channel 3 = A5, then 8'h80 with channel 7 = 3C. One-cycle latency, no bubbles.
- Backpressure: out_ready[3]=0, send 8'h11 to sel 3, then 8'h22 to sel 3 -> second word sees in_ready=0 and channel 3 holds 8'h11. A concurrent word 8'h33 to sel 4 is accepted. Raising out_ready[3] accepts 8'h22 in the same cycle 8'h11 drains.
- Broadcast: out_ready=8'hFE with channel 0 full, send in_bcast=1 with 8'h5A -> in_ready=0. Set out_ready[0]=1 -> accepted, and the next cycle out_valid=8'hFF with all channels = 5A.
- Drop: N_OUT=6, SEL_W=3, send sel=6 and sel=7 three hundred times -> in_ready=1 every cycle, out_valid stays 0, drop_cnt saturates at 255.
- Full-rate stress: random out_ready and random sel/bcast for 10k cycles -> a scoreboard shows per-channel order preserved, no loss or duplication, and out_data stable while stalled.
